// File: rtl/serial_word_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_rx_pkg : shared types and constants for serial_word_rx       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic IDLE_LEVEL    = 1'b1;
  localparam logic START_LEVEL   = 1'b0;
  localparam int   DEFAULT_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/rx_bit_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_bit_counter : data-bit up-counter, tc flags the last data bit    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module rx_bit_counter
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/serial_word_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_word_rx : start/WIDTH data (LSB first)/stop frame receiver   |
// | Revision 1.0 ; SERIAL_WORD_RX_PARITY_EN adds an even-parity bit     |
// +--------------------------------------------------------------------+
module serial_word_rx
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
`ifdef SERIAL_WORD_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  rx_state_t        state;
  rx_state_t        state_n;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_n;
  logic [WIDTH-1:0] data_n;
  logic             valid_n;
  logic             frame_err_n;
  logic             busy_n;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_tc;
`ifdef SERIAL_WORD_RX_PARITY_EN
  logic             par_bit;
  logic             par_n;
  logic             parity_err_n;
`endif

  rx_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      data_out  <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
      busy      <= busy_n;
`ifdef SERIAL_WORD_RX_PARITY_EN
      par_bit    <= par_n;
      parity_err <= parity_err_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    shift_n     = shift_reg;
    data_n      = data_out;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
    par_n        = par_bit;
    parity_err_n = 1'b0;
`endif
    if (en) begin
      case (state)
        IDLE: begin
          if (din == START_LEVEL) begin
            state_n = DATA;
            cnt_clr = 1'b1;
          end
        end
        DATA: begin
          // Right shift: the first data bit ends up in the LSB.
          shift_n = {din, shift_reg[WIDTH-1:1]};
          if (cnt_tc) begin
            cnt_clr = 1'b1;
`ifdef SERIAL_WORD_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            cnt_inc = 1'b1;
          end
        end
`ifdef SERIAL_WORD_RX_PARITY_EN
        PARITY: begin
          par_n   = din;
          state_n = STOP;
        end
`endif
        STOP: begin
          state_n = IDLE;
          if (din == IDLE_LEVEL) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
            if (par_bit != (^shift_reg)) begin
              parity_err_n = 1'b1;
            end else begin
              data_n  = shift_reg;
              valid_n = 1'b1;
            end
`else
            data_n  = shift_reg;
            valid_n = 1'b1;
`endif
          end else begin
            frame_err_n = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
    busy_n = (state_n != IDLE);
  end

endmodule
`default_nettype wire
